qspi_bus_arbiter: RTL and testbench

//  Arbitrates the shared quad-SPI bus (flash + PSRAM share SCLK/IO[3:0]) between the

---
 rtl/qspi_arb_pkg.sv | 18 +
 rtl/qspi_bus_arbiter.sv | 113 +++++++++++
 tb/tb_qspi_bus_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_arb_pkg.sv
// Shared definitions for the quad-SPI bus arbiter, mem_ctl request logic and SPI engine.
package qspi_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_GAP   = 2'd2
  } arb_state_e;

  // Requester bit positions in i_req / o_gnt
  localparam int REQ_INSTR = 0;
  localparam int REQ_DATA  = 1;

  // Target select: drives flash_cs_n vs ram_cs_n in the engine
  localparam logic TGT_FLASH = 1'b0;
  localparam logic TGT_PSRAM = 1'b1;

endpackage

// File: rtl/qspi_bus_arbiter.sv
// Shared quad-SPI bus arbiter: one grant per transaction, CS-high gap between
// transactions, forced PSRAM burst break before the tCEM limit.
module qspi_bus_arbiter
  import qspi_arb_pkg::*;
#(
  parameter int CS_GAP_CYCLES    = 2,
  parameter int PSRAM_MAX_CYCLES = 400,
  parameter int STARVE_LIMIT     = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_tgt_instr,
  input  logic       i_tgt_data,
  input  logic       i_done,
  output logic [1:0] o_gnt,
  output logic       o_tgt,
  output logic       o_start,
  output logic       o_brk,
  output logic       o_busy
);

  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam int HW = (PSRAM_MAX_CYCLES > 1) ? $clog2(PSRAM_MAX_CYCLES + 1) : 1;
  localparam int GW = (CS_GAP_CYCLES > 1) ? $clog2(CS_GAP_CYCLES + 1) : 1;

  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [HW-1:0] HOLD_LAST  = HW'(PSRAM_MAX_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'((CS_GAP_CYCLES > 0) ? CS_GAP_CYCLES - 1 : 0);

  arb_state_e    state_q;
  logic [1:0]    gnt_q;
  logic          tgt_q;
  logic          start_q;
  logic          brk_q;
  logic [SW-1:0] starve_q;
  logic [HW-1:0] hold_q;
  logic [GW-1:0] gap_q;
  logic [1:0]    win_d;

  // Next winner (one-hot). Data has priority unless instr has been passed over
  // STARVE_LIMIT times in a row; a lone requester always wins.
  function automatic logic [1:0] next_winner(logic [1:0] req, logic [SW-1:0] starve);
    if (!req[REQ_INSTR])      return 2'b10;
    if (!req[REQ_DATA])       return 2'b01;
    if ((STARVE_LIMIT != 0) && (starve == STARVE_MAX)) return 2'b01;
    return 2'b10;
  endfunction

  // Winner is only consumed in IDLE with a non-zero request
  assign win_d = next_winner(i_req, starve_q);

  // Arbiter FSM with registered grant/target/start/break outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ARB_IDLE;
      gnt_q    <= 2'b00;
      tgt_q    <= TGT_FLASH;
      start_q  <= 1'b0;
      brk_q    <= 1'b0;
      starve_q <= '0;
      hold_q   <= '0;
      gap_q    <= '0;
    end else begin
      start_q <= 1'b0;
      unique case (state_q)
        ARB_IDLE: begin
          if (|i_req) begin
            state_q <= ARB_GRANT;
            gnt_q   <= win_d;
            tgt_q   <= win_d[REQ_DATA] ? i_tgt_data : i_tgt_instr;
            start_q <= 1'b1;
            hold_q  <= '0;
            // Instr grant resets starvation; data win over a waiting instr counts
            if (win_d[REQ_INSTR])
              starve_q <= '0;
            else if (i_req[REQ_INSTR] && (starve_q != STARVE_MAX))
              starve_q <= starve_q + SW'(1);
          end
        end
        ARB_GRANT: begin
          if (i_done) begin
            gnt_q <= 2'b00;
            tgt_q <= TGT_FLASH;
            brk_q <= 1'b0;
            gap_q <= '0;
            state_q <= (CS_GAP_CYCLES > 0) ? ARB_GAP : ARB_IDLE;
          end else if (tgt_q == TGT_PSRAM) begin
            // Counter parks at the limit; break stays up until the engine finishes
            if (hold_q == HOLD_LAST)
              brk_q <= 1'b1;
            else
              hold_q <= hold_q + HW'(1);
          end
        end
        ARB_GAP: begin
          if (gap_q == GAP_LAST)
            state_q <= ARB_IDLE;
          else
            gap_q <= gap_q + GW'(1);
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  assign o_gnt   = gnt_q;
  assign o_tgt   = tgt_q;
  assign o_start = start_q;
  assign o_brk   = brk_q;
  assign o_busy  = (state_q != ARB_IDLE);

endmodule

// File: tb/tb_qspi_bus_arbiter.sv
// Bench for qspi_bus_arbiter: two configurations driven by shared stimulus,
// each checked every cycle against a transaction-level reference model.
module tb_qspi_bus_arbiter;

  localparam int G0 = 2, P0 = 24, S0 = 4;
  localparam int G1 = 0, P1 = 16, S1 = 0;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] req = 2'b00;
  logic       ti = 1'b0, td = 1'b0, done = 1'b0;
  logic [1:0] gnt [2];
  logic       tgt [2], st [2], brk [2], busy [2];

  int n_tests = 0, n_fail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  qspi_bus_arbiter #(.CS_GAP_CYCLES(G0), .PSRAM_MAX_CYCLES(P0), .STARVE_LIMIT(S0)) u0 (
    .clk(clk), .rst_n(rst_n), .i_req(req), .i_tgt_instr(ti), .i_tgt_data(td), .i_done(done),
    .o_gnt(gnt[0]), .o_tgt(tgt[0]), .o_start(st[0]), .o_brk(brk[0]), .o_busy(busy[0]));

  qspi_bus_arbiter #(.CS_GAP_CYCLES(G1), .PSRAM_MAX_CYCLES(P1), .STARVE_LIMIT(S1)) u1 (
    .clk(clk), .rst_n(rst_n), .i_req(req), .i_tgt_instr(ti), .i_tgt_data(td), .i_done(done),
    .o_gnt(gnt[1]), .o_tgt(tgt[1]), .o_start(st[1]), .o_brk(brk[1]), .o_busy(busy[1]));

  // ---------------- reference model (transaction level) ----------------
  // own: -1 none, 0 instr, 1 data. age: cycles since o_start. gapl: CS-high cycles left.
  int own [2] = '{-1, -1};
  int age [2] = '{0, 0};
  int gapl [2] = '{0, 0};
  int stv [2] = '{0, 0};
  bit mt [2] = '{0, 0};
  bit mst [2] = '{0, 0};

  always @(posedge clk or negedge rst_n) begin
    int g, s, w;
    if (!rst_n) begin
      for (int d = 0; d < 2; d++) begin
        own[d] = -1; age[d] = 0; gapl[d] = 0; stv[d] = 0; mt[d] = 0; mst[d] = 0;
      end
    end else begin
      for (int d = 0; d < 2; d++) begin
        g = (d == 0) ? G0 : G1;
        s = (d == 0) ? S0 : S1;
        mst[d] = 0;
        if (own[d] >= 0) begin
          if (done) begin own[d] = -1; gapl[d] = g; end
          else age[d] = age[d] + 1;
        end else if (gapl[d] > 0) begin
          gapl[d] = gapl[d] - 1;
        end else if (req != 2'b00) begin
          if (req == 2'b01) w = 0;
          else if (req == 2'b10) w = 1;
          else w = (s != 0 && stv[d] == s) ? 0 : 1;
          own[d] = w; age[d] = 0; mst[d] = 1;
          mt[d] = (w == 1) ? td : ti;
          if (w == 0) stv[d] = 0;
          else if (req[0] && stv[d] < s) stv[d] = stv[d] + 1;
        end
      end
    end
  end

  // Per-cycle comparison of both DUTs against the model
  always @(negedge clk) begin
    logic [1:0] eg;
    logic et, eb, ebz;
    int p;
    for (int d = 0; d < 2; d++) begin
      p = (d == 0) ? P0 : P1;
      eg = (own[d] == 1) ? 2'b10 : ((own[d] == 0) ? 2'b01 : 2'b00);
      et = (own[d] >= 0) ? mt[d] : 1'b0;
      eb = (own[d] >= 0) && mt[d] && (age[d] >= p);
      ebz = (own[d] >= 0) || (gapl[d] > 0);
      n_tests++;
      if (gnt[d] !== eg || tgt[d] !== et || st[d] !== mst[d] || brk[d] !== eb || busy[d] !== ebz) begin
        n_fail++;
        $display("FAIL cmp_u%0d cyc=%0d got gnt=%b tgt=%b start=%b brk=%b busy=%b expected gnt=%b tgt=%b start=%b brk=%b busy=%b",
                 d, cyc, gnt[d], tgt[d], st[d], brk[d], busy[d], eg, et, mst[d], eb, ebz);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string nm, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic wait_start(input int d, output int ok);
    ok = 0;
    for (int i = 0; i < 200; i++) begin
      if (st[d]) begin ok = 1; break; end
      tick();
    end
    if (ok == 0) begin
      n_tests++; n_fail++;
      $display("FAIL wait_start_u%0d: got timeout expected o_start", d);
    end
  endtask

  // Grants on u0 with i_done 3 cycles after each o_start; e[k]=1 means data expected
  task automatic run_seq(input string nm, input int n, input bit e [10]);
    int ok;
    for (int k = 0; k < n; k++) begin
      wait_start(0, ok);
      check($sformatf("%s_%0d", nm, k), gnt[0], e[k] ? 2 : 1);
      repeat (3) tick();
      done = 1'b1; tick(); done = 1'b0;
    end
  endtask

  bit exp2 [10];
  bit exp5 [10];

  initial begin
    int ok, s0, s1, n;
    exp2 = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    exp5 = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};

    // Reset state
    #1 rst_n = 1'b0;
    repeat (3) tick();
    check("rst_gnt", gnt[0], 0); check("rst_start", st[0], 0);
    check("rst_brk", brk[0], 0); check("rst_busy", busy[0], 0); check("rst_tgt", tgt[0], 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // 1: lone instr fetch from flash
    req = 2'b01; ti = 1'b0;
    tick();
    check("t1_gnt", gnt[0], 1); check("t1_start", st[0], 1);
    tick();
    check("t1_start_width", st[0], 0);
    repeat (4) tick();
    done = 1'b1; tick(); done = 1'b0; req = 2'b00;
    check("t1_gnt_drop", gnt[0], 0); check("t1_busy_gap1", busy[0], 1);
    tick(); check("t1_busy_gap2", busy[0], 1);
    tick(); check("t1_busy_idle", busy[0], 0);

    // 2: both requesting, starvation limit 4
    req = 2'b11; ti = 1'b0; td = 1'b0;
    run_seq("t2_order", 10, exp2);

    // 3: PSRAM data grant, i_done withheld
    req = 2'b10; td = 1'b1;
    wait_start(0, ok);
    for (int k = 1; k <= P0 + 3; k++) begin
      tick();
      if (k == P0 - 1) check("t3_brk_before", brk[0], 0);
      if (k == P0)     check("t3_brk_rise", brk[0], 1);
    end
    check("t3_brk_hold", brk[0], 1); check("t3_gnt_hold", gnt[0], 2);
    done = 1'b1; tick(); done = 1'b0; req = 2'b00;
    check("t3_brk_clr", brk[0], 0); check("t3_gnt_clr", gnt[0], 0);

    // 4: i_done in the o_start cycle
    req = 2'b10; td = 1'b0;
    wait_start(0, ok);
    s0 = cyc;
    done = 1'b1; tick(); done = 1'b0;
    check("t4_one_cycle", gnt[0], 0);
    wait_start(0, ok);
    check("t4_spacing", cyc - s0, G0 + 2);
    done = 1'b1; tick(); done = 1'b0; req = 2'b00;

    // 5: async reset mid-grant with o_brk up
    repeat (3) tick();
    req = 2'b10; td = 1'b1;
    wait_start(0, ok);
    repeat (P0) tick();
    check("t5_brk_pre", brk[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check("t5_gnt0", gnt[0], 0); check("t5_brk0", brk[0], 0); check("t5_busy0", busy[0], 0);
    check("t5_start0", st[0], 0); check("t5_tgt0", tgt[0], 0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("t5_regrant", gnt[0], 2); check("t5_restart", st[0], 1);
    req = 2'b11; td = 1'b0; ti = 1'b0;
    run_seq("t5_order", 6, exp5);

    // Drain both configurations to idle
    req = 2'b00; done = 1'b1; tick(); tick(); done = 1'b0; repeat (4) tick();

    // 6: no CS gap (u1), back-to-back data
    req = 2'b10; td = 1'b0;
    wait_start(1, ok);
    for (int k = 0; k < 3; k++) begin
      s1 = cyc;
      repeat (3) tick();
      done = 1'b1; tick(); done = 1'b0;
      check($sformatf("t6_gap_%0d", k), gnt[1], 0);
      wait_start(1, ok);
      check($sformatf("t6_spacing_%0d", k), cyc - s1, 5);
    end
    req = 2'b00; done = 1'b1; tick(); done = 1'b0; repeat (4) tick();

    // Random phase, model-checked every cycle
    n = 0;
    repeat (4000) begin
      if ($urandom_range(7) == 0) req[0] = ~req[0];
      if ($urandom_range(7) == 0) req[1] = ~req[1];
      ti = 1'($urandom_range(1));
      td = 1'($urandom_range(1));
      done = ($urandom_range(11) == 0);
      if ($urandom_range(999) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
        n++;
      end
      tick();
    end
    done = 1'b0; req = 2'b00;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
